// File: rtl/wb_sram_arb.sv
// Two-master Wishbone B3 arbiter sharing one SRAM slave port.
// Round-robin grant held for the whole cyc; a watchdog ends stalled strobes with err.
module wb_sram_arb #(
   parameter int unsigned DW      = 32,
   parameter int unsigned AW      = 32,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned TO_W    = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   // master 0
   input  logic [AW-1:0]     m0_adr_i,
   input  logic [DW-1:0]     m0_dat_i,
   input  logic [DW/8-1:0]   m0_sel_i,
   input  logic [2:0]        m0_cti_i,
   input  logic [1:0]        m0_bte_i,
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   output logic              m0_rty_o,
   output logic [DW-1:0]     m0_dat_o,
   // master 1
   input  logic [AW-1:0]     m1_adr_i,
   input  logic [DW-1:0]     m1_dat_i,
   input  logic [DW/8-1:0]   m1_sel_i,
   input  logic [2:0]        m1_cti_i,
   input  logic [1:0]        m1_bte_i,
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   output logic              m1_rty_o,
   output logic [DW-1:0]     m1_dat_o,
   // SRAM slave
   output logic [AW-1:0]     s_adr_o,
   output logic [DW-1:0]     s_dat_o,
   output logic [DW/8-1:0]   s_sel_o,
   output logic [2:0]        s_cti_o,
   output logic [1:0]        s_bte_o,
   output logic              s_we_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   input  logic              s_ack_i,
   input  logic              s_err_i,
   input  logic              s_rty_i,
   input  logic [DW-1:0]     s_dat_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_e;

   localparam bit             TO_EN  = (TIMEOUT != 0);
   localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0] TO_M1  = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   // Elaboration-time parameter sanity
   if (!(DW == 32 || DW == 16 || DW == 8)) begin : g_bad_dw
      $error("wb_sram_arb: DW must be 32, 16 or 8");
   end
   if (TO_W < 32 && 64'(TIMEOUT) >= (64'd1 << TO_W)) begin : g_bad_to
      $error("wb_sram_arb: TIMEOUT must be below 2**TO_W");
   end

   state_e          state_q, state_d;
   logic            prio_q, prio_d;
   logic [TO_W-1:0] cnt_q, cnt_d;

   logic            cur_cyc;
   logic            cur_stb;
   logic            any_rsp;
   logic            to_fire;
   logic            gnt0;
   logic            gnt1;

   // State, priority pointer and watchdog registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         cnt_q   <= cnt_d;
      end
   end

   // Grant FSM: ownership changes only when the owner drops cyc
   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      unique case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = prio_q ? G1 : G0;
            end else if (m0_cyc_i) begin
               state_d = G0;
            end else if (m1_cyc_i) begin
               state_d = G1;
            end
         end
         G0: begin
            if (!m0_cyc_i) begin
               prio_d  = 1'b1;
               state_d = m1_cyc_i ? G1 : IDLE;
            end
         end
         G1: begin
            if (!m1_cyc_i) begin
               prio_d  = 1'b0;
               state_d = m0_cyc_i ? G0 : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Slave-side mux; in IDLE the payload follows m0 but cyc/stb stay low
   always_comb begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_cti_o = m0_cti_i;
      s_bte_o = m0_bte_i;
      s_we_o  = m0_we_i;
      cur_cyc = 1'b0;
      cur_stb = 1'b0;
      if (state_q == G1) begin
         s_adr_o = m1_adr_i;
         s_dat_o = m1_dat_i;
         s_sel_o = m1_sel_i;
         s_cti_o = m1_cti_i;
         s_bte_o = m1_bte_i;
         s_we_o  = m1_we_i;
         cur_cyc = m1_cyc_i;
         cur_stb = m1_stb_i;
      end else if (state_q == G0) begin
         cur_cyc = m0_cyc_i;
         cur_stb = m0_stb_i;
      end
   end

   assign any_rsp = s_ack_i | s_err_i | s_rty_i;
   assign to_fire = TO_EN & (cnt_q == TO_M1) & cur_stb & ~any_rsp;

   // Watchdog counts consecutive unanswered strobe cycles of the owner
   always_comb begin
      cnt_d = cnt_q;
      if (!cur_stb || any_rsp || to_fire) begin
         cnt_d = '0;
      end else if (cnt_q != TO_LIM) begin
         cnt_d = cnt_q + TO_W'(1);
      end
   end

   assign s_cyc_o = cur_cyc;
   assign s_stb_o = cur_stb & ~to_fire;

   // Response routing to the owner only
   assign gnt0     = (state_q == G0);
   assign gnt1     = (state_q == G1);
   assign m0_ack_o = gnt0 & s_ack_i & ~to_fire;
   assign m0_rty_o = gnt0 & s_rty_i;
   assign m0_err_o = gnt0 & (s_err_i | to_fire);
   assign m1_ack_o = gnt1 & s_ack_i & ~to_fire;
   assign m1_rty_o = gnt1 & s_rty_i;
   assign m1_err_o = gnt1 & (s_err_i | to_fire);
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

endmodule
